// File: rtl/mult_pkg.sv
// Shared constants, types and helpers for the pipelined multiply/MAC unit.
// Default parameters are also used by the result-RAM writer so both sides
// agree on the result width.
package mult_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_LAT     = 2;
  localparam int unsigned DEF_SIGNED  = 0;
  localparam int unsigned DEF_GUARD_W = 8;

  // Result/accumulator width: full product plus accumulation guard bits.
  function automatic int unsigned out_w(input int unsigned data_w,
                                        input int unsigned guard_w);
    return 2 * data_w + guard_w;
  endfunction

  localparam int unsigned DEF_OUT_W = out_w(DEF_DATA_W, DEF_GUARD_W);

  // Stage contents at the default width (valid bit, accumulate flag, value).
  typedef struct packed {
    logic                 valid;
    logic                 acc;
    logic [DEF_OUT_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/mult_stage.sv
// One elastic pipeline register with valid/ready flow control.
//   clk, rst_n : clock, async active-low reset
//   i_valid    : upstream holds a beat
//   i_data     : upstream payload
//   o_ready    : this stage loads on the next edge (empty or advancing)
//   o_valid    : this stage holds a beat
//   o_data     : held payload
//   i_ready    : downstream loads on the next edge
module mult_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // An empty stage always loads, so bubbles collapse while the output stalls.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined multiply / multiply-accumulate with valid/ready on both sides.
//   clk, rst_n   : clock, async active-low reset
//   data0, data1 : operands (DATA_W)
//   acc          : 1 = add product to previous result, 0 = start new sum
//   data_valid   : input beat present
//   data_ready   : beat accepted this cycle (combinational through the stages)
//   mult0        : result (OUT_W)
//   mult_valid   : mult0 holds a result
//   mult_ready   : sink takes the result this cycle
//   occupancy    : beats in flight, including the output register
module mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned  DATA_W  = DEF_DATA_W,
  parameter int unsigned  LAT     = DEF_LAT,
  parameter int unsigned  SIGNED  = DEF_SIGNED,
  parameter int unsigned  GUARD_W = DEF_GUARD_W,
  localparam int unsigned OUT_W   = out_w(DATA_W, GUARD_W),
  localparam int unsigned OCC_W   = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              acc,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [OUT_W-1:0]  mult0,
  output logic              mult_valid,
  input  logic              mult_ready,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int unsigned P_W = 2 * DATA_W;

  typedef struct packed {
    logic             acc;
    logic [OUT_W-1:0] prod;
  } pay_t;

  localparam int unsigned PAY_W = $bits(pay_t);

  logic [OUT_W-1:0] w_prod;
  logic             w_vld [LAT];
  pay_t             w_pay [LAT];
  logic             w_rdy [1:LAT];
  logic [OUT_W-1:0] w_sum;
  logic             w_accept;
  logic             w_consume;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_mult0;
  logic [OCC_W-1:0] r_occ;

  // Full-width product, then sign/zero extension into the guard bits.
  if (SIGNED != 0) begin : g_signed
    logic signed [P_W-1:0] w_a;
    logic signed [P_W-1:0] w_b;
    logic signed [P_W-1:0] w_p;
    assign w_a    = P_W'($signed(data0));
    assign w_b    = P_W'($signed(data1));
    assign w_p    = w_a * w_b;
    assign w_prod = OUT_W'(w_p);
  end else begin : g_unsigned
    logic [P_W-1:0] w_p;
    assign w_p    = P_W'(data0) * P_W'(data1);
    assign w_prod = OUT_W'(w_p);
  end

  // Index 0 is the input port; stage k (1..LAT-1) drives index k.
  assign w_vld[0] = data_valid;
  assign w_pay[0] = '{acc: acc, prod: w_prod};

  for (genvar k = 1; k < LAT; k++) begin : g_stage
    mult_stage #(.W(PAY_W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_vld[k-1]),
      .i_data  (w_pay[k-1]),
      .o_ready (w_rdy[k]),
      .o_valid (w_vld[k]),
      .o_data  (w_pay[k]),
      .i_ready (w_rdy[k+1])
    );
  end

  assign w_rdy[LAT] = !r_out_valid || mult_ready;
  assign data_ready = w_rdy[1];
  assign w_accept   = data_valid && data_ready;
  assign w_consume  = r_out_valid && mult_ready;

  // The output register doubles as the accumulator: both take the same value
  // on every entry and reset to zero, so one register serves both roles.
  assign w_sum = w_pay[LAT-1].acc ? (r_mult0 + w_pay[LAT-1].prod)
                                  : w_pay[LAT-1].prod;

  // Output / accumulate stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_mult0     <= '0;
    end else if (w_rdy[LAT]) begin
      r_out_valid <= w_vld[LAT-1];
      if (w_vld[LAT-1]) begin
        r_mult0 <= w_sum;
      end
    end
  end

  // In-flight beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_consume);
    end
  end

  assign mult0      = r_mult0;
  assign mult_valid = r_out_valid;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: main unsigned LAT=3 instance with scoreboard, plus a
// signed LAT=2 instance and a zero-guard LAT=1 instance for width corners.
module tb_mult_pipe;

  localparam int unsigned LAT   = 3;
  localparam int unsigned OUT_W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance
  logic [7:0]       data0 = '0, data1 = '0;
  logic             acc = 1'b0, data_valid = 1'b0, mult_ready = 1'b0;
  logic             data_ready, mult_valid;
  logic [OUT_W-1:0] mult0;
  logic [1:0]       occupancy;

  mult_pipe #(.DATA_W(8), .LAT(LAT), .SIGNED(0), .GUARD_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .data0(data0), .data1(data1), .acc(acc),
    .data_valid(data_valid), .data_ready(data_ready), .mult0(mult0),
    .mult_valid(mult_valid), .mult_ready(mult_ready), .occupancy(occupancy)
  );

  // Signed instance
  logic [7:0]  sg_d0 = '0, sg_d1 = '0;
  logic        sg_acc = 1'b0, sg_valid = 1'b0, sg_ready = 1'b1;
  logic        sg_data_ready, sg_mult_valid;
  logic [23:0] sg_mult0;
  logic [1:0]  sg_occ;

  mult_pipe #(.DATA_W(8), .LAT(2), .SIGNED(1), .GUARD_W(8)) u_sgn (
    .clk(clk), .rst_n(rst_n), .data0(sg_d0), .data1(sg_d1), .acc(sg_acc),
    .data_valid(sg_valid), .data_ready(sg_data_ready), .mult0(sg_mult0),
    .mult_valid(sg_mult_valid), .mult_ready(sg_ready), .occupancy(sg_occ)
  );

  // Zero-guard wrap instance
  logic [7:0]  wr_d0 = '0, wr_d1 = '0;
  logic        wr_acc = 1'b0, wr_valid = 1'b0, wr_ready = 1'b1;
  logic        wr_data_ready, wr_mult_valid;
  logic [15:0] wr_mult0;
  logic [0:0]  wr_occ;

  mult_pipe #(.DATA_W(8), .LAT(1), .SIGNED(0), .GUARD_W(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .data0(wr_d0), .data1(wr_d1), .acc(wr_acc),
    .data_valid(wr_valid), .data_ready(wr_data_ready), .mult0(wr_mult0),
    .mult_valid(wr_mult_valid), .mult_ready(wr_ready), .occupancy(wr_occ)
  );

  // Scoreboard: expected pushed on accept, compared on consume.
  logic [OUT_W-1:0] sb_q[$];
  logic [OUT_W-1:0] got_q[$];
  logic [OUT_W-1:0] model_acc = '0;
  logic [OUT_W-1:0] hold_val = '0;
  bit               hold_pend = 1'b0;

  always @(negedge clk) begin
    logic [OUT_W-1:0] prod, exp_v;
    if (!rst_n) begin
      sb_q.delete();
      model_acc = '0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (mult_valid !== 1'b1 || mult0 !== hold_val) begin
          failures++;
          $display("FAIL hold_stable got valid=%b mult0=%0d exp valid=1 mult0=%0d",
                   mult_valid, mult0, hold_val);
        end
      end
      hold_pend = (mult_valid === 1'b1) && !mult_ready;
      hold_val  = mult0;
      if (mult_valid === 1'b1 && mult_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%0d exp=none", mult0);
        end else begin
          exp_v = sb_q.pop_front();
          if (mult0 !== exp_v) begin
            failures++;
            $display("FAIL sb_data got=%0d exp=%0d", mult0, exp_v);
          end
        end
        got_q.push_back(mult0);
      end
      if (data_valid && data_ready) begin
        prod = OUT_W'(data0) * OUT_W'(data1);
        model_acc = acc ? model_acc + prod : prod;
        sb_q.push_back(model_acc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Helpers (no comparisons inside)
  task automatic wait_drain(output bit ok);
    int n = 0;
    while (occupancy != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (occupancy == 0);
  endtask

  task automatic fill_pipe(output int cnt);
    cnt = 0;
    @(posedge clk); #1;
    mult_ready = 1'b0;
    data_valid = 1'b1;
    data0 = 8'($urandom); data1 = 8'($urandom); acc = 1'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!data_ready) break;
      cnt++;
      @(posedge clk); #1;
      data0 = 8'($urandom); data1 = 8'($urandom); acc = 1'($urandom);
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           input logic ac, output bit ok);
    @(posedge clk); #1;
    data0 = a; data1 = b; acc = ac; data_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", data_ready); end
    checks++; if (mult_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mult_valid); end
    checks++; if (mult0 !== '0) begin failures++; $display("FAIL reset_mult0 got=%0d exp=0", mult0); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_single();
    got_q.delete();
    @(posedge clk); #1;
    data0 = 8'd200; data1 = 8'd150; acc = 1'b0; data_valid = 1'b1; mult_ready = 1'b0;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(posedge clk); #1;
      data_valid = 1'b0;
      checks++;
      if (i < int'(LAT)) begin
        if (mult_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0 edge=%0d", mult_valid, i); end
      end else if (mult_valid !== 1'b1 || mult0 !== 24'd30000) begin
        failures++; $display("FAIL single_result got valid=%b mult0=%0d exp valid=1 mult0=30000", mult_valid, mult0);
      end
    end
    checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
    repeat (3) @(posedge clk); #1;
    checks++; if (mult_valid !== 1'b1) begin failures++; $display("FAIL single_held got=%b exp=1", mult_valid); end
    mult_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (mult_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", mult_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL single_occ_end got=%0d exp=0", occupancy); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_fill();
    int cnt;
    bit ok;
    fill_pipe(cnt);
    checks++; if (cnt != int'(LAT)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", cnt, LAT); end
    checks++; if (occupancy !== 2'(LAT)) begin failures++; $display("FAIL fill_occ got=%0d exp=%0d", occupancy, LAT); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_low got=%b exp=0", data_ready); end
    mult_ready = 1'b1;
    #1;
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL fill_release got=%b exp=1", data_ready); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fill_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_accumulate(input bit stall);
    logic [7:0]       a0 [4];
    logic [7:0]       a1 [4];
    logic             ac [4];
    logic [OUT_W-1:0] ex [4];
    bit ok;
    a0 = '{8'd3, 8'd5, 8'd2, 8'd1};
    a1 = '{8'd4, 8'd6, 8'd2, 8'd1};
    ac = '{1'b0, 1'b1, 1'b1, 1'b0};
    ex = '{24'd12, 24'd42, 24'd46, 24'd1};
    got_q.delete();
    mult_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_beat(a0[b], a1[b], ac[b], ok);
      checks++; if (!ok) begin failures++; $display("FAIL acc_accept got=timeout exp=accept beat=%0d", b); end
      if (stall) begin
        mult_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mult_ready = 1'b1;
      end
    end
    wait_drain(ok);
    checks++; if (!ok || got_q.size() != 4) begin failures++; $display("FAIL acc_count got=%0d exp=4 stall=%0d", got_q.size(), stall); end
    for (int b = 0; b < 4 && b < got_q.size(); b++) begin
      checks++;
      if (got_q[b] !== ex[b]) begin failures++; $display("FAIL acc_value got=%0d exp=%0d beat=%0d stall=%0d", got_q[b], ex[b], b, stall); end
    end
  endtask

  task automatic test_stream();
    int  sent = 0;
    int  cyc = 0;
    bit  hit = 1'b0;
    got_q.delete();
    data_valid = 1'b0;
    while ((sent < 20 || occupancy != 0) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (!data_valid || hit) begin
        if (sent < 20 && $urandom_range(0, 3) != 0) begin
          data_valid = 1'b1;
          data0 = 8'($urandom); data1 = 8'($urandom); acc = 1'($urandom);
        end else begin
          data_valid = 1'b0;
        end
      end
      mult_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      hit = data_valid && data_ready;
      if (hit) sent++;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    mult_ready = 1'b1;
    checks++; if (sent != 20) begin failures++; $display("FAIL stream_sent got=%0d exp=20", sent); end
    checks++; if (got_q.size() != 20) begin failures++; $display("FAIL stream_recv got=%0d exp=20", got_q.size()); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL stream_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit ok;
    fill_pipe(cnt);
    checks++; if (mult_valid !== 1'b1 || occupancy !== 2'(LAT)) begin failures++; $display("FAIL mid_pre got valid=%b occ=%0d exp valid=1 occ=%0d", mult_valid, occupancy, LAT); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mult_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", mult_valid); end
    checks++; if (mult0 !== '0) begin failures++; $display("FAIL mid_mult0 got=%0d exp=0", mult0); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", data_ready); end
    got_q.delete();
    mult_ready = 1'b1;
    send_beat(8'd2, 8'd3, 1'b1, ok);
    wait_drain(ok);
    checks++; if (got_q.size() != 1 || got_q[0] !== 24'd6) begin failures++; $display("FAIL mid_first got=%0d exp=6 n=%0d", (got_q.size() != 0) ? got_q[0] : 24'd0, got_q.size()); end
  endtask

  task automatic test_signed();
    logic [7:0]  d0 [2];
    logic [7:0]  d1 [2];
    logic [23:0] ex [2];
    bit found;
    d0 = '{8'h80, 8'hFD};
    d1 = '{8'h80, 8'h07};
    ex = '{24'h004000, 24'hFFFFEB};
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      checks++; if (sg_data_ready !== 1'b1) begin failures++; $display("FAIL signed_ready got=%b exp=1", sg_data_ready); end
      sg_d0 = d0[p]; sg_d1 = d1[p]; sg_acc = 1'b0; sg_valid = 1'b1;
      @(posedge clk); #1;
      sg_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (sg_mult_valid) begin found = 1'b1; break; end
      end
      checks++; if (!found || sg_mult0 !== ex[p]) begin failures++; $display("FAIL signed_value got=%h exp=%h pair=%0d", sg_mult0, ex[p], p); end
    end
    @(posedge clk); #1;
    checks++; if (sg_occ !== 2'd0) begin failures++; $display("FAIL signed_occ got=%0d exp=0", sg_occ); end
  endtask

  task automatic test_wrap();
    logic        ac [2];
    logic [15:0] ex [2];
    bit found;
    ac = '{1'b0, 1'b1};
    ex = '{16'd65025, 16'd64514};
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      checks++; if (wr_data_ready !== 1'b1) begin failures++; $display("FAIL wrap_ready got=%b exp=1", wr_data_ready); end
      wr_d0 = 8'd255; wr_d1 = 8'd255; wr_acc = ac[p]; wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (wr_mult_valid) begin found = 1'b1; break; end
        @(negedge clk);
      end
      checks++; if (!found || wr_mult0 !== ex[p]) begin failures++; $display("FAIL wrap_value got=%0d exp=%0d beat=%0d", wr_mult0, ex[p], p); end
    end
    @(posedge clk); #1;
    checks++; if (wr_occ !== 1'b0) begin failures++; $display("FAIL wrap_occ got=%0d exp=0", wr_occ); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_accumulate(1'b0);
    test_accumulate(1'b1);
    test_stream();
    test_signed();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
